// File: rtl/i_cache_ctrl.sv
// Control FSM for a 2-way, 8-set instruction cache: tag compare, miss fill, 1-bit LRU victim choice.
// Optional one-block-lookahead prefetch after a demand fill, enabled by defining I_CACHE_PREFETCH_EN.
module i_cache_ctrl #(
    parameter int TAG_W = 24,
    parameter int IDX_W = 3,
    parameter int OFF_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_read,
    input  logic [31:0]      cpu_addr,
    output logic             cpu_resp,
    output logic             hit_way,
    input  logic [TAG_W-1:0] tag0_i,
    input  logic [TAG_W-1:0] tag1_i,
    input  logic             valid0_i,
    input  logic             valid1_i,
    input  logic             busy0_i,
    input  logic             busy1_i,
    input  logic [TAG_W-1:0] obl_tag0_i,
    input  logic [TAG_W-1:0] obl_tag1_i,
    input  logic             obl_valid0_i,
    input  logic             obl_valid1_i,
    input  logic             obl_busy_i,
    output logic [IDX_W-1:0] index_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             read_data_o,
    output logic [1:0]       load_way_o,
    output logic             load_busy_o,
    output logic             busy_o,
    output logic             pmem_read,
    output logic [31:0]      pmem_addr,
    input  logic             pmem_resp
);
    localparam int LINE_W = 32 - OFF_W;
    localparam int NSETS  = 1 << IDX_W;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMP      = 3'd1,
        FILL     = 3'd2,
        ALLOC    = 3'd3,
        PF_CHK   = 3'd4,
        PF_FILL  = 3'd5,
        PF_ALLOC = 3'd6
    } state_t;

    state_t              state_reg;
    logic [LINE_W-1:0]   line_reg;
    logic                victim_reg;
    logic [NSETS-1:0]    lru_reg;

    logic [TAG_W-1:0]    way_tag   [2];
    logic                way_valid [2];
    logic [1:0]          hit;
    logic [TAG_W-1:0]    cur_tag;
    logic [IDX_W-1:0]    cur_idx;
    logic                hit_sel;
    logic                cur_victim;

    assign way_tag[0]   = tag0_i;
    assign way_tag[1]   = tag1_i;
    assign way_valid[0] = valid0_i;
    assign way_valid[1] = valid1_i;
    assign cur_tag      = line_reg[LINE_W-1 -: TAG_W];
    assign cur_idx      = line_reg[IDX_W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_way_hit
            assign hit[gi] = way_valid[gi] && (way_tag[gi] == cur_tag);
        end
    endgenerate

    // Way 0 wins a (should-not-happen) double hit; invalid ways are filled before evicting.
    assign hit_sel    = ~hit[0];
    assign cur_victim = !valid0_i ? 1'b0 : (!valid1_i ? 1'b1 : lru_reg[cur_idx]);

`ifdef I_CACHE_PREFETCH_EN
    logic                pf_pending_reg;
    logic [LINE_W-1:0]   next_line;
    logic [TAG_W-1:0]    next_tag;
    logic [IDX_W-1:0]    next_idx;
    logic                obl_present;
    logic                pf_victim;

    assign next_line   = line_reg + 1'b1;
    assign next_tag    = next_line[LINE_W-1 -: TAG_W];
    assign next_idx    = next_line[IDX_W-1:0];
    assign obl_present = (obl_valid0_i && (obl_tag0_i == next_tag)) ||
                         (obl_valid1_i && (obl_tag1_i == next_tag));
    assign pf_victim   = !obl_valid0_i ? 1'b0 : (!obl_valid1_i ? 1'b1 : lru_reg[next_idx]);

    logic unused_ok;
    assign unused_ok = ^{busy0_i, busy1_i, cpu_addr[OFF_W-1:0]};
`else
    logic unused_ok;
    assign unused_ok = ^{busy0_i, busy1_i, cpu_addr[OFF_W-1:0], obl_tag0_i, obl_tag1_i,
                         obl_valid0_i, obl_valid1_i, obl_busy_i};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            line_reg    <= '0;
            victim_reg  <= 1'b0;
            lru_reg     <= '0;
            cpu_resp    <= 1'b0;
            hit_way     <= 1'b0;
            index_o     <= '0;
            tag_o       <= '0;
            read_data_o <= 1'b0;
            load_way_o  <= '0;
            load_busy_o <= 1'b0;
            busy_o      <= 1'b0;
            pmem_read   <= 1'b0;
            pmem_addr   <= '0;
`ifdef I_CACHE_PREFETCH_EN
            pf_pending_reg <= 1'b0;
`endif
        end else begin
            cpu_resp    <= 1'b0;
            read_data_o <= 1'b0;
            load_way_o  <= '0;
            load_busy_o <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // Ignore the request still held high in the cycle of its own response.
                    if (cpu_read && !cpu_resp) begin
                        line_reg    <= cpu_addr[31:OFF_W];
                        index_o     <= cpu_addr[OFF_W +: IDX_W];
                        read_data_o <= 1'b1;
                        state_reg   <= CMP;
                    end
                end
                CMP: begin
                    if (|hit) begin
                        cpu_resp         <= 1'b1;
                        hit_way          <= hit_sel;
                        lru_reg[cur_idx] <= ~hit_sel;
`ifdef I_CACHE_PREFETCH_EN
                        pf_pending_reg   <= 1'b0;
                        state_reg        <= pf_pending_reg ? PF_CHK : IDLE;
`else
                        state_reg        <= IDLE;
`endif
                    end else begin
                        victim_reg  <= cur_victim;
                        load_busy_o <= 1'b1;
                        busy_o      <= 1'b1;
                        pmem_read   <= 1'b1;
                        pmem_addr   <= {line_reg, {OFF_W{1'b0}}};
                        state_reg   <= FILL;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        pmem_read              <= 1'b0;
                        load_way_o[victim_reg] <= 1'b1;
                        tag_o                  <= cur_tag;
                        load_busy_o            <= 1'b1;
                        busy_o                 <= 1'b0;
                        read_data_o            <= 1'b1;
                        state_reg              <= ALLOC;
                    end
                end
                ALLOC: begin
                    // An abandoned request still gets its line installed, but no response.
                    if (cpu_read) begin
                        read_data_o <= 1'b1;
                        state_reg   <= CMP;
                    end else begin
                        state_reg   <= IDLE;
                    end
`ifdef I_CACHE_PREFETCH_EN
                    pf_pending_reg <= cpu_read;
`endif
                end
`ifdef I_CACHE_PREFETCH_EN
                PF_CHK: begin
                    if (!obl_present && !obl_busy_i) begin
                        victim_reg  <= pf_victim;
                        index_o     <= next_idx;
                        load_busy_o <= 1'b1;
                        busy_o      <= 1'b1;
                        pmem_read   <= 1'b1;
                        pmem_addr   <= {next_line, {OFF_W{1'b0}}};
                        state_reg   <= PF_FILL;
                    end else begin
                        state_reg   <= IDLE;
                    end
                end
                PF_FILL: begin
                    if (pmem_resp) begin
                        pmem_read              <= 1'b0;
                        load_way_o[victim_reg] <= 1'b1;
                        tag_o                  <= pmem_addr[31 -: TAG_W];
                        load_busy_o            <= 1'b1;
                        busy_o                 <= 1'b0;
                        state_reg              <= PF_ALLOC;
                    end
                end
                PF_ALLOC: begin
                    state_reg <= IDLE;
                end
`endif
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i_cache_ctrl.sv
// Bench for i_cache_ctrl: behavioural ways + memory around the FSM, checked against a set/way cache model.
module tb_i_cache_ctrl;
    localparam int TAG_W = 24;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             cpu_read;
    logic [31:0]      cpu_addr;
    logic             cpu_resp;
    logic             hit_way;
    logic [TAG_W-1:0] tag0_i, tag1_i, obl_tag0_i, obl_tag1_i;
    logic             valid0_i, valid1_i, busy0_i, busy1_i;
    logic             obl_valid0_i, obl_valid1_i, obl_busy_i;
    logic [IDX_W-1:0] index_o;
    logic [TAG_W-1:0] tag_o;
    logic             read_data_o;
    logic [1:0]       load_way_o;
    logic             load_busy_o;
    logic             busy_o;
    logic             pmem_read;
    logic [31:0]      pmem_addr;
    logic             pmem_resp;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    always #5 clk = ~clk;

    i_cache_ctrl dut (
        .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_addr(cpu_addr),
        .cpu_resp(cpu_resp), .hit_way(hit_way),
        .tag0_i(tag0_i), .tag1_i(tag1_i), .valid0_i(valid0_i), .valid1_i(valid1_i),
        .busy0_i(busy0_i), .busy1_i(busy1_i),
        .obl_tag0_i(obl_tag0_i), .obl_tag1_i(obl_tag1_i),
        .obl_valid0_i(obl_valid0_i), .obl_valid1_i(obl_valid1_i), .obl_busy_i(obl_busy_i),
        .index_o(index_o), .tag_o(tag_o), .read_data_o(read_data_o),
        .load_way_o(load_way_o), .load_busy_o(load_busy_o), .busy_o(busy_o),
        .pmem_read(pmem_read), .pmem_addr(pmem_addr), .pmem_resp(pmem_resp)
    );

    // Behavioural tag/valid/busy storage of the two ways
    logic [TAG_W-1:0] m_tag   [2][8];
    logic             m_valid [2][8];
    logic             m_busy  [2][8];
    logic [IDX_W-1:0] obl_idx;

    assign obl_idx      = index_o + 3'd1;
    assign tag0_i       = m_tag[0][index_o];
    assign tag1_i       = m_tag[1][index_o];
    assign valid0_i     = m_valid[0][index_o];
    assign valid1_i     = m_valid[1][index_o];
    assign busy0_i      = m_busy[0][index_o];
    assign busy1_i      = m_busy[1][index_o];
    assign obl_tag0_i   = m_tag[0][obl_idx];
    assign obl_tag1_i   = m_tag[1][obl_idx];
    assign obl_valid0_i = m_valid[0][obl_idx];
    assign obl_valid1_i = m_valid[1][obl_idx];
    assign obl_busy_i   = m_busy[0][obl_idx] | m_busy[1][obl_idx];

    always @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < 2; w++)
                for (int s = 0; s < 8; s++) begin
                    m_tag[w][s]   <= '0;
                    m_valid[w][s] <= 1'b0;
                    m_busy[w][s]  <= 1'b0;
                end
        end else begin
            for (int w = 0; w < 2; w++) begin
                if (load_way_o[w]) begin
                    m_tag[w][index_o]   <= tag_o;
                    m_valid[w][index_o] <= 1'b1;
                end
                if (load_busy_o) m_busy[w][index_o] <= busy_o;
            end
        end
    end

    // Reference cache contents
    int ref_tag   [2][8];
    bit ref_valid [2][8];
    int ref_lru   [8];

    task automatic ref_clear();
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 8; s++) begin
                ref_valid[w][s] = 1'b0;
                ref_tag[w][s]   = 0;
            end
        for (int s = 0; s < 8; s++) ref_lru[s] = 0;
    endtask

    task automatic check(input string tag_s, input logic [31:0] obs, input logic [31:0] exp_v);
        assert_cnt++;
        if (obs !== exp_v) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag_s, obs, exp_v);
        end
    endtask

    // One fetch; drop=1 abandons the request once the line read starts (only applied to misses).
    task automatic fetch(input logic [31:0] addr, input int mem_delay, input bit drop);
        int       idx, tg, exp_way, cyc, pm_cycles, load_seen, exp_lat;
        bit       exp_hit, done, got_resp, do_drop;
        logic [1:0] exp_oh;
        idx = int'(addr[7:5]);
        tg  = int'(addr[31:8]);
        exp_hit = 1'b0;
        exp_way = 0;
        if (ref_valid[0][idx] && ref_tag[0][idx] == tg) begin
            exp_hit = 1'b1; exp_way = 0;
        end else if (ref_valid[1][idx] && ref_tag[1][idx] == tg) begin
            exp_hit = 1'b1; exp_way = 1;
        end else begin
            exp_way = !ref_valid[0][idx] ? 0 : (!ref_valid[1][idx] ? 1 : ref_lru[idx]);
        end
        do_drop  = drop && !exp_hit;
        exp_oh   = 2'b01 << exp_way;
        exp_lat  = exp_hit ? 2 : 4 + (mem_delay + 1);
        cyc = 0; pm_cycles = 0; load_seen = 0; done = 1'b0; got_resp = 1'b0;

        @(negedge clk);
        cpu_addr = addr;
        cpu_read = 1'b1;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            pmem_resp = 1'b0;
            if (cyc == 1) begin
                check("cmp_index", 32'(index_o), 32'(idx));
                check("cmp_read_data", 32'(read_data_o), 32'd1);
            end
            if (pmem_read) begin
                pm_cycles++;
                if (pm_cycles == 1) begin
                    check("pmem_addr", pmem_addr, {addr[31:5], 5'b0});
                    check("fill_load_busy", 32'({load_busy_o, busy_o}), 32'b11);
                    if (do_drop) cpu_read = 1'b0;
                end
                if (pm_cycles == mem_delay + 1) pmem_resp = 1'b1;
            end
            if (load_way_o != 2'b00) begin
                load_seen++;
                check("load_way", 32'(load_way_o), 32'(exp_oh));
                check("alloc_tag", 32'(tag_o), 32'(tg));
                check("alloc_busy", 32'({load_busy_o, busy_o, read_data_o}), 32'b101);
                if (do_drop) done = 1'b1;
            end
            if (cpu_resp) begin
                got_resp = 1'b1;
                check("latency", 32'(cyc), 32'(exp_lat));
                check("hit_way", 32'(hit_way), 32'(exp_way));
                cpu_read = 1'b0;
                done = 1'b1;
            end
        end
        pmem_resp = 1'b0;
        cpu_read  = 1'b0;
        if (do_drop) check("drop_resp", 32'(got_resp), 32'd0);
        else         check("resp_seen", 32'(got_resp), 32'd1);
        check("load_count", 32'(load_seen), exp_hit ? 32'd0 : 32'd1);
        if (exp_hit) check("hit_no_pmem", 32'(pm_cycles), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("quiet_after", 32'({cpu_resp, pmem_read}), 32'd0);
        end
        if (!exp_hit) begin
            ref_valid[exp_way][idx] = 1'b1;
            ref_tag[exp_way][idx]   = tg;
        end
        if (!do_drop) ref_lru[idx] = 1 - exp_way;
        $display("fetch addr=0x%08h hit=%0d way=%0d drop=%0d delay=%0d cycles=%0d",
                 addr, exp_hit, exp_way, do_drop, mem_delay, cyc);
    endtask

    // Reset during FILL: line read must be withdrawn and a late pmem_resp ignored.
    task automatic reset_in_fill(input logic [31:0] addr);
        int cyc;
        @(negedge clk);
        cpu_addr = addr;
        cpu_read = 1'b1;
        cyc = 0;
        while (!pmem_read && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_fill_reached", 32'(pmem_read), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_pmem_read", 32'(pmem_read), 32'd0);
        check("rst_outputs", 32'({cpu_resp, load_way_o, load_busy_o, busy_o}), 32'd0);
        rst = 1'b0;
        cpu_read = 1'b0;
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        @(negedge clk);
        check("rst_late_resp", 32'({pmem_read, load_way_o, cpu_resp}), 32'd0);
        ref_clear();
        $display("reset during fill addr=0x%08h", addr);
    endtask

    initial begin
        logic [31:0] a;
        logic [23:0] tag_pool [4];
        tag_pool[0] = 24'h000010; tag_pool[1] = 24'h000020;
        tag_pool[2] = 24'h000030; tag_pool[3] = 24'hFFFFFF;
        rst = 1'b1; cpu_read = 1'b0; cpu_addr = '0; pmem_resp = 1'b0;
        ref_clear();
        repeat (3) @(negedge clk);
        check("rst_cpu_resp", 32'(cpu_resp), 32'd0);
        check("rst_pmem_read", 32'(pmem_read), 32'd0);
        check("rst_load_way", 32'(load_way_o), 32'd0);
        check("rst_load_busy", 32'(load_busy_o), 32'd0);
        check("rst_read_data", 32'(read_data_o), 32'd0);
        check("rst_hit_way", 32'(hit_way), 32'd0);
        check("rst_index", 32'(index_o), 32'd0);
        check("rst_tag", 32'(tag_o), 32'd0);
        rst = 1'b0;

        fetch(32'h0000_1020, 4, 1'b0);
        fetch(32'h0000_1024, 0, 1'b0);
        fetch(32'h0000_2020, 1, 1'b0);
        fetch(32'h0000_1024, 0, 1'b0);
        fetch(32'h0000_3020, 2, 1'b0);
        fetch(32'h0000_2028, 0, 1'b0);
        fetch(32'h0000_10E0, 3, 1'b0);
        fetch(32'h0000_1100, 0, 1'b0);
        fetch(32'hFFFF_FFE0, 1, 1'b0);
        fetch(32'h0000_4060, 2, 1'b1);
        fetch(32'h0000_4064, 0, 1'b0);
        reset_in_fill(32'h0000_5020);
        fetch(32'h0000_1020, 0, 1'b0);
        fetch(32'h0000_1020, 0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            a = {tag_pool[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
            fetch(a, $urandom_range(0, 5), ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
